// File: rtl/spi_master_drv_if.sv
// Handshake and serial-pin bundle between an SPI master driver and its environment.
// The master view is the driver itself; the slave view is the upstream sequencer plus SPI device.
interface spi_master_drv_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  spi_start;
    logic [DATA_WIDTH-1:0] spi_data;
    logic                  spi_finish;
    logic                  busy;
    logic                  spi_cs_n;
    logic                  spi_sclk;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic [DATA_WIDTH-1:0] rx_data;

    modport master (
        input  spi_start, spi_data, spi_miso,
        output spi_finish, busy, spi_cs_n, spi_sclk, spi_mosi, rx_data
    );

    modport slave (
        output spi_start, spi_data, spi_miso,
        input  spi_finish, busy, spi_cs_n, spi_sclk, spi_mosi, rx_data
    );
endinterface

// File: rtl/spi_master_drv.sv
// Mode-0 SPI master: one DATA_WIDTH-bit full-duplex word per spi_start, MSB first,
// with programmable SCLK divider and chip-select setup/hold; all outputs registered.
module spi_master_drv #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_master_drv_if.master   bus
);
    localparam int CNT_W = 16;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_r;
    logic [CNT_W-1:0]      cnt_r;
    logic [BIT_W-1:0]      bit_cnt_r;
    // tx_r holds the bits still to be sent after the one currently on mosi
    logic [DATA_WIDTH-1:0] tx_r;
    logic [DATA_WIDTH-1:0] rx_r;
    logic [DATA_WIDTH-1:0] rx_data_r;
    logic                  cs_n_r;
    logic                  sclk_r;
    logic                  mosi_r;
    logic                  finish_r;
    logic                  busy_r;

    // Transaction sequencer: state, timing counters, shift registers and pin outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= 16'd0;
            bit_cnt_r <= BIT_W'(0);
            tx_r      <= {DATA_WIDTH{1'b0}};
            rx_r      <= {DATA_WIDTH{1'b0}};
            rx_data_r <= {DATA_WIDTH{1'b0}};
            cs_n_r    <= 1'b1;
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b0;
            finish_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    finish_r <= 1'b0;
                    sclk_r   <= 1'b0;
                    cnt_r    <= 16'd0;
                    if (bus.spi_start) begin
                        tx_r      <= {bus.spi_data[DATA_WIDTH-2:0], 1'b0};
                        mosi_r    <= bus.spi_data[DATA_WIDTH-1];
                        rx_r      <= {DATA_WIDTH{1'b0}};
                        bit_cnt_r <= BIT_W'(0);
                        cs_n_r    <= 1'b0;
                        busy_r    <= 1'b1;
                        state_r   <= SETUP;
                    end else begin
                        mosi_r <= 1'b0;
                        cs_n_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt_r == CNT_W'(CS_SETUP - 1)) begin
                        cnt_r   <= 16'd0;
                        state_r <= SHIFT;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_r != CNT_W'(CLK_DIV - 1)) begin
                        cnt_r <= cnt_r + 16'd1;
                    end else if (!sclk_r) begin
                        // rising SCLK: sample the slave's bit
                        cnt_r  <= 16'd0;
                        sclk_r <= 1'b1;
                        rx_r   <= {rx_r[DATA_WIDTH-2:0], bus.spi_miso};
                    end else if (bit_cnt_r == BIT_W'(DATA_WIDTH - 1)) begin
                        cnt_r   <= 16'd0;
                        sclk_r  <= 1'b0;
                        state_r <= HOLD;
                    end else begin
                        // falling SCLK: present the next bit
                        cnt_r     <= 16'd0;
                        sclk_r    <= 1'b0;
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                        mosi_r    <= tx_r[DATA_WIDTH-1];
                        tx_r      <= {tx_r[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                HOLD: begin
                    if (cnt_r == CNT_W'(CS_HOLD - 1)) begin
                        cnt_r     <= 16'd0;
                        cs_n_r    <= 1'b1;
                        mosi_r    <= 1'b0;
                        finish_r  <= 1'b1;
                        rx_data_r <= rx_r;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                DONE: begin
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    cs_n_r   <= 1'b1;
                    sclk_r   <= 1'b0;
                    mosi_r   <= 1'b0;
                    finish_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.spi_cs_n   = cs_n_r;
    assign bus.spi_sclk   = sclk_r;
    assign bus.spi_mosi   = mosi_r;
    assign bus.spi_finish = finish_r;
    assign bus.busy       = busy_r;
    assign bus.rx_data    = rx_data_r;
endmodule

// File: tb/tb_spi_master_drv.sv
// Randomized bench for spi_master_drv: default and fastest-corner instances, a mode-0 slave
// model, and a transaction-level reference (latency formula, words in/out, pulse counts).
module tb_spi_master_drv;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          sel = 1'b0;
    logic [DW-1:0] data = 16'h0000;
    logic          miso_s;

    always #5 clk = ~clk;

    spi_master_drv_if #(.DATA_WIDTH(DW)) bus0 ();
    spi_master_drv_if #(.DATA_WIDTH(DW)) bus1 ();

    assign bus0.spi_start = start & ~sel;
    assign bus1.spi_start = start & sel;
    assign bus0.spi_data  = data;
    assign bus1.spi_data  = data;
    assign bus0.spi_miso  = miso_s;
    assign bus1.spi_miso  = miso_s;

    spi_master_drv #(.DATA_WIDTH(DW), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    spi_master_drv #(.DATA_WIDTH(DW), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic          obs_cs_n, obs_sclk, obs_mosi, obs_finish, obs_busy;
    logic [DW-1:0] obs_rx;
    assign obs_cs_n   = sel ? bus1.spi_cs_n   : bus0.spi_cs_n;
    assign obs_sclk   = sel ? bus1.spi_sclk   : bus0.spi_sclk;
    assign obs_mosi   = sel ? bus1.spi_mosi   : bus0.spi_mosi;
    assign obs_finish = sel ? bus1.spi_finish : bus0.spi_finish;
    assign obs_busy   = sel ? bus1.busy       : bus0.busy;
    assign obs_rx     = sel ? bus1.rx_data    : bus0.rx_data;

    // Mode-0 slave: loads its word at cs_n fall, shifts out on SCLK fall, records MOSI on SCLK rise
    logic [DW-1:0] slave_word = 16'h0000;
    logic [DW-1:0] slave_sr = 16'h0000;
    logic [DW-1:0] mosi_cap = 16'h0000;
    int            sclk_pulses = 0;
    assign miso_s = slave_sr[DW-1];

    always @(negedge obs_cs_n) begin
        slave_sr    <= slave_word;
        mosi_cap    <= 16'h0000;
        sclk_pulses <= 0;
    end
    always @(negedge obs_sclk) slave_sr <= {slave_sr[DW-2:0], 1'b0};
    always @(posedge obs_sclk) begin
        mosi_cap    <= {mosi_cap[DW-2:0], obs_mosi};
        sclk_pulses <= sclk_pulses + 1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0: quiet; mode 1: random starts while busy; mode 2: starts sampled at edges 10 and N-1
    task automatic run_xfer(input logic [DW-1:0] word, input logic [DW-1:0] rword, input int mode);
        int n_exp;
        int cyc;
        int cs_low;
        int fin_at;
        n_exp = sel ? (1 + 2 * 1 * DW + 1) : (2 + 2 * 4 * DW + 2);
        slave_word = rword;
        @(negedge clk);
        data  = word;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        data  = DW'($urandom);
        check_eq("busy_on_accept", {31'd0, obs_busy}, 32'd1);
        check_eq("cs_low_on_accept", {31'd0, obs_cs_n}, 32'd0);
        cyc = 0; cs_low = 0; fin_at = -1;
        while (fin_at < 0 && cyc < 400) begin
            if (obs_cs_n == 1'b0) cs_low++;
            if (mode == 1) begin
                start = 1'($urandom_range(0, 1));
                data  = DW'($urandom);
            end else if (mode == 2) begin
                start = (cyc == 9 || cyc == n_exp - 2) ? 1'b1 : 1'b0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (obs_finish) fin_at = cyc;
        end
        check_eq("finish_latency", 32'(fin_at), 32'(n_exp));
        check_eq("cs_low_cycles", 32'(cs_low), 32'(n_exp));
        check_eq("sclk_pulses", 32'(sclk_pulses), 32'(DW));
        check_eq("mosi_word", {16'd0, mosi_cap}, {16'd0, word});
        check_eq("rx_at_finish", {16'd0, obs_rx}, {16'd0, rword});
        check_eq("done_cs_n", {31'd0, obs_cs_n}, 32'd1);
        check_eq("done_busy", {31'd0, obs_busy}, 32'd1);
        check_eq("done_mosi", {31'd0, obs_mosi}, 32'd0);
        start = (mode != 0) ? 1'b1 : 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("post_busy", {31'd0, obs_busy}, 32'd0);
        check_eq("post_finish", {31'd0, obs_finish}, 32'd0);
        @(posedge clk); #1;
        check_eq("no_queued_start", {30'd0, obs_cs_n, obs_busy}, 32'd2);
        check_eq("rx_hold", {16'd0, obs_rx}, {16'd0, rword});
        check_eq("idle_mosi", {30'd0, obs_mosi, obs_sclk}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq(tag, {16'd0, obs_rx}, 32'd0);
        check_eq({tag, "_pins"}, {27'd0, obs_cs_n, obs_sclk, obs_mosi, obs_finish, obs_busy}, 32'h10);
    endtask

    initial begin
        int k;
        int fin_seen;
        logic [DW-1:0] w;
        // start held high through reset must be ignored
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        check_eq("no_start_from_reset", {31'd0, obs_busy}, 32'd0);

        run_xfer(16'h0E00, 16'hA5C3, 0);
        run_xfer(16'h8001, 16'h7FFE, 2);

        // abort mid-shift
        @(negedge clk);
        data = 16'hFFFF; slave_word = 16'h1234; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (sclk_pulses < 7 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("reached_bit7", 32'(sclk_pulses), 32'd7);
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        check_reset_state("abort_state");
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        fin_seen = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (obs_finish || !obs_cs_n) fin_seen++;
        end
        check_eq("abort_no_activity", 32'(fin_seen), 32'd0);
        run_xfer(16'hC3A5, 16'h0F0F, 0);

        // upstream sequencer chain with random gaps and random start noise while busy
        for (int i = 0; i < 15; i++) begin
            w = DW'($urandom);
            run_xfer(w, DW'($urandom), 1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // fastest corner instance
        sel = 1'b1;
        @(posedge clk); #1;
        run_xfer(16'h0E00, 16'hA5C3, 0);
        for (int i = 0; i < 5; i++) begin
            run_xfer(DW'($urandom), DW'($urandom), (i % 2 == 0) ? 1 : 0);
        end
        run_xfer(16'hFFFF, 16'h0000, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
